// File: rtl/ltl_report_collector.sv
// Collects automata report lines: timestamps every run cycle that carries a report,
// queues it in a small FIFO drained over valid/ready, and keeps sticky hit/overflow status.
module ltl_report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int TS_W        = 16,
  parameter int DEPTH       = 8,
  parameter int DROP_W      = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       run,
  input  logic                       clear,
  input  logic [NUM_REPORTS-1:0]     report,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_W-1:0]            evt_ts,
  output logic [NUM_REPORTS-1:0]     evt_report,
  output logic                       hit_sticky,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = TS_W + NUM_REPORTS;

  logic [LVL_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [LVL_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic               hit_q, hit_d;
  logic               ovf_q, ovf_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [LVL_W-1:0]   level_w;
  logic [ENTRY_W-1:0] head_w;
  logic               full_w;
  logic               pop_w;
  logic               push_req_w;
  logic               push_ok_w;
  logic               drop_w;

  // Counters carry one extra MSB so full and empty are distinguishable.
  assign level_w    = wr_cnt_q - rd_cnt_q;
  assign full_w     = (level_w == LVL_W'(DEPTH));
  assign evt_valid  = (level_w != '0);
  assign pop_w      = evt_valid & evt_ready;
  assign push_req_w = run & (|report);
  assign push_ok_w  = push_req_w & (~full_w | pop_w);
  assign drop_w     = push_req_w & full_w & ~pop_w;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    ts_d     = ts_q;
    hit_d    = hit_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (clear) begin
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      ts_d     = '0;
      hit_d    = 1'b0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      if (run)        ts_d     = ts_q + 1'b1;
      if (push_ok_w)  wr_cnt_d = wr_cnt_q + 1'b1;
      if (pop_w)      rd_cnt_d = rd_cnt_q + 1'b1;
      if (push_req_w) hit_d    = 1'b1;
      if (drop_w) begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      ts_q     <= '0;
      hit_q    <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      ts_q     <= ts_d;
      hit_q    <= hit_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok_w && !clear) begin
      mem_q[wr_cnt_q[PTR_W-1:0]] <= {ts_q, report};
    end
  end

  assign head_w     = mem_q[rd_cnt_q[PTR_W-1:0]];
  assign evt_ts     = evt_valid ? head_w[ENTRY_W-1:NUM_REPORTS] : '0;
  assign evt_report = evt_valid ? head_w[NUM_REPORTS-1:0] : '0;
  assign hit_sticky = hit_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign level      = level_w;

endmodule

// File: tb/tb_ltl_report_collector.sv
// Randomized bench for ltl_report_collector: a queue-based reference model feeds a
// scoreboard that a separate monitor drains whenever the DUT hands over an event.
module tb_ltl_report_collector;
  localparam int NR  = 4;
  localparam int TSW = 4;
  localparam int DEP = 8;
  localparam int DW  = 3;
  localparam int LW  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic          clear = 1'b0;
  logic [NR-1:0] report = '0;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [TSW-1:0] evt_ts;
  logic [NR-1:0] evt_report;
  logic          hit_sticky;
  logic          overflow;
  logic [DW-1:0] drop_count;
  logic [LW-1:0] level;

  ltl_report_collector #(.NUM_REPORTS(NR), .TS_W(TSW), .DEPTH(DEP), .DROP_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .clear(clear), .report(report),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ts(evt_ts), .evt_report(evt_report),
    .hit_sticky(hit_sticky), .overflow(overflow), .drop_count(drop_count), .level(level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: expected FIFO contents and status, in plain integers.
  logic [7:0] exp_q[$];
  int         m_level = 0;
  int         m_ts    = 0;
  int         m_hit   = 0;
  int         m_ovf   = 0;
  int         m_drops = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_level = 0; m_ts = 0; m_hit = 0; m_ovf = 0; m_drops = 0;
  endfunction

  function automatic void model_step(input logic r, input logic c, input logic [3:0] rep,
                                     input logic rdy);
    int pop;
    if (c) begin
      model_reset();
      return;
    end
    pop = (m_level > 0 && rdy) ? 1 : 0;
    if (r && rep != 4'b0000) begin
      m_hit = 1;
      if (m_level < DEP || pop == 1) begin
        exp_q.push_back({4'(m_ts), rep});
        m_level++;
      end else begin
        m_ovf = 1;
        if (m_drops < (1 << DW) - 1) m_drops++;
      end
    end
    m_level -= pop;
    if (r) m_ts = (m_ts + 1) % (1 << TSW);
  endfunction

  function automatic void check_status();
    chk("evt_valid", 32'(evt_valid), 32'(m_level > 0));
    chk("level", 32'(level), 32'(m_level));
    chk("hit_sticky", 32'(hit_sticky), 32'(m_hit));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
  endfunction

  task automatic cycle(input logic r, input logic c, input logic [3:0] rep, input logic rdy);
    run = r; clear = c; report = rep; evt_ready = rdy;
    @(posedge clk); #1;
    model_step(r, c, rep, rdy);
    check_status();
  endtask

  // Monitor: compares every handed-over event against the scoreboard head.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && !clear && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pop: got ts=%0d report=%b expected no event", evt_ts, evt_report);
        end else begin
          e = exp_q.pop_front();
          chk("evt_ts", 32'(evt_ts), 32'(e[7:4]));
          chk("evt_report", 32'(evt_report), 32'(e[3:0]));
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_evt_valid", 32'(evt_valid), 0);
    chk("rst_evt_ts", 32'(evt_ts), 0);
    chk("rst_evt_report", 32'(evt_report), 0);
    chk("rst_level", 32'(level), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_status();

    // Quiet run cycles then a single report
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    cycle(1'b1, 1'b0, 4'b1000, 1'b1);
    chk("basic_head_ts", 32'(evt_ts), 5);
    cycle(1'b0, 1'b0, 4'b0000, 1'b1);

    // Fill past full, then push+pop at full, then saturate drop counter
    cycle(1'b0, 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 4'b0001, 1'b0);
    chk("full_drop_count", 32'(drop_count), 2);
    cycle(1'b1, 1'b0, 4'b0010, 1'b1);
    chk("full_pushpop_level", 32'(level), DEP);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'b0100, 1'b0);
    chk("drop_saturated", 32'(drop_count), 7);

    // Clear with a coincident report
    cycle(1'b1, 1'b1, 4'b0100, 1'b0);
    chk("clear_level", 32'(level), 0);

    // Run gating and timestamp wrap
    for (int i = 0; i < 20; i++) cycle(1'(i % 2), 1'b0, 4'b1111, 1'b1);
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 4'b1111, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, c, rdy;
      logic [3:0] rep;
      r   = ($urandom_range(0, 3) != 0);
      c   = ($urandom_range(0, 39) == 0);
      rep = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      rdy = ($urandom_range(0, 1) == 1);
      cycle(r, c, rep, rdy);
    end

    // Asynchronous reset with entries queued
    cycle(1'b0, 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'b0011, 1'b0);
    run = 1'b0; clear = 1'b0; report = '0; evt_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_evt_valid", 32'(evt_valid), 0);
    chk("async_level", 32'(level), 0);
    chk("async_drop_count", 32'(drop_count), 0);
    chk("async_hit", 32'(hit_sticky), 0);
    model_reset();
    @(posedge clk); #2;
    reset_n = 1'b1;
    cycle(1'b1, 1'b0, 4'b0100, 1'b0);
    chk("post_reset_ts", 32'(evt_ts), 0);

    // Drain everything
    for (int i = 0; i < DEP + 3; i++) cycle(1'b0, 1'b0, 4'b0000, 1'b1);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
